// File: rtl/frame_sequencer.sv
// frame_sequencer: APU frame step sequencer with QF/HF strobes; sticky IRQ only when FRAMESEQ_IRQ_EN is defined
module frame_sequencer #(
  parameter int STEP_PERIOD = 3728,
  parameter int CNT_W       = 12,
  parameter int STEPS0      = 4,
  parameter int STEPS1      = 5,
  parameter int STEP_W      = 3
) (
  input  logic              CLK,
  input  logic              RES,
  input  logic              ACLK_EN,
  input  logic              WR,
  input  logic [1:0]        DIN,
  input  logic              ACK,
  output logic              QF,
  output logic              HF,
  output logic              IRQ,
  output logic [STEP_W-1:0] STEP
);
  logic              mode, pend;
  logic [CNT_W-1:0]  cnt;
  logic [STEP_W-1:0] step;
  logic              tick, apply, step_end, last, silent, qf_d, hf_d;
  always_comb begin
    apply    = ACLK_EN && pend;
    tick     = ACLK_EN && !pend;
    step_end = tick && cnt == CNT_W'(STEP_PERIOD - 1);
    last     = step == (mode ? STEP_W'(STEPS1 - 1) : STEP_W'(STEPS0 - 1));
    silent   = mode && step == STEP_W'(STEPS1 - 2);
    qf_d     = (step_end && !silent) || (apply && mode);
    hf_d     = (step_end && !silent && (step[0] || last)) || (apply && mode);
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      mode <= 1'b0;
      pend <= 1'b0;
      cnt  <= '0;
      step <= '0;
      QF   <= 1'b0;
      HF   <= 1'b0;
    end else begin
      mode <= WR ? DIN[1] : mode;
      pend <= WR || (pend && !ACLK_EN);
      cnt  <= (apply || step_end) ? '0 : tick ? cnt + 1'b1 : cnt;
      step <= apply ? '0 : step_end ? (last ? '0 : step + 1'b1) : step;
      QF   <= qf_d;
      HF   <= hf_d;
    end
  end
  assign STEP = step;
`ifdef FRAMESEQ_IRQ_EN
  logic inhibit, irq, irq_set, irq_clr;
  always_comb begin
    irq_clr = ACK || (WR && DIN[0]);
    irq_set = step_end && !mode && last && !inhibit && !(WR && DIN[0]);
  end
  always_ff @(posedge CLK) begin
    if (RES) begin
      inhibit <= 1'b0;
      irq     <= 1'b0;
    end else begin
      inhibit <= WR ? DIN[0] : inhibit;
      irq     <= irq_set ? 1'b1 : irq_clr ? 1'b0 : irq;
    end
  end
  assign IRQ = irq;
`else
  logic unused_irq;
  assign unused_irq = ^{ACK, DIN[0]};
  assign IRQ = 1'b0;
`endif
endmodule
